// File: rtl/axi4lite_flash_reader.sv
// AXI4-lite read master: streams word_count 64-bit words from the flash slave into a valid/ready sink.
// Optional build macro AXI4LITE_FLASH_READER_ABORT_ON_ERR_EN: first error response stops issue and discards data.
module axi4lite_flash_reader #(
   parameter int ADDR_WIDTH      = 24,
   parameter int DATA_WIDTH      = 64,
   parameter int LEN_WIDTH       = 16,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [LEN_WIDTH-1:0]  word_count,
   output logic                  busy,
   output logic                  done,
   output logic                  error,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH-1:0] araddr,
   output logic [2:0]            arprot,
   output logic                  arvalid,
   input  logic                  arready,
   input  logic [DATA_WIDTH-1:0] rdata,
   input  logic [1:0]            rresp,
   input  logic                  rvalid,
   output logic                  rready
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(DATA_WIDTH / 8);
   localparam logic [CNT_W:0]        CREDITS  = (CNT_W + 1)'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  arvalid_q, arvalid_d;
   logic [LEN_WIDTH-1:0]  count_q, count_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [CNT_W-1:0]      outst_q, outst_d;
   logic [CNT_W-1:0]      occ_q, occ_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [MAX_OUTSTANDING];
   logic [DATA_WIDTH-1:0] mem_d [MAX_OUTSTANDING];
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
`ifdef AXI4LITE_FLASH_READER_ABORT_ON_ERR_EN
   logic                  abort_q, abort_d;
`endif
   logic                  ar_hs, r_hs, r_err, push, pop, stop_issue;

   always_comb begin
      ar_hs = arvalid_q & arready;
      r_hs  = busy_q & rvalid;
      r_err = r_hs & (rresp != 2'b00);
      pop   = (occ_q != '0) & out_ready;
`ifdef AXI4LITE_FLASH_READER_ABORT_ON_ERR_EN
      abort_d    = (state_q == IDLE) ? 1'b0 : (abort_q | r_err);
      push       = r_hs & ~r_err & ~abort_q;
      stop_issue = abort_d;
`else
      push       = r_hs;
      stop_issue = 1'b0;
`endif
      state_d   = state_q;
      addr_d    = ar_hs ? (addr_q + STRIDE) : addr_q;
      arvalid_d = 1'b0;
      count_d   = count_q;
      issued_d  = issued_q + LEN_WIDTH'(ar_hs);
      outst_d   = outst_q + CNT_W'(ar_hs) - CNT_W'(r_hs);
      occ_d     = occ_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d  = push ? ((wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
      rd_ptr_d  = pop  ? ((rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
      mem_d     = mem_q;
      if (push) mem_d[wr_ptr_q] = rdata;
      error_d   = error_q | r_err;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               error_d  = 1'b0;
               addr_d   = start_addr;
               count_d  = word_count;
               issued_d = '0;
               if (word_count != '0) begin
                  state_d   = RUN;
                  arvalid_d = 1'b1;
               end else begin
                  state_d = FIN;
                  done_d  = 1'b1;
               end
            end
         end
         RUN: begin
            // A presented request is held until accepted; otherwise re-evaluate credit on next-cycle counts.
            if (arvalid_q & ~arready)
               arvalid_d = 1'b1;
            else
               arvalid_d = ~stop_issue & (issued_d != count_q) &
                           (({1'b0, outst_d} + {1'b0, occ_d}) < CREDITS);
            if ((issued_d == count_q) || (stop_issue && !arvalid_d))
               state_d = DRAIN;
         end
         DRAIN: begin
            if ((outst_q == '0) && (occ_q == '0)) begin
               state_d = FIN;
               done_d  = 1'b1;
            end
         end
         FIN: state_d = IDLE;
      endcase

      busy_d = (state_d == RUN) || (state_d == DRAIN);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         arvalid_q <= 1'b0;
         count_q   <= '0;
         issued_q  <= '0;
         outst_q   <= '0;
         occ_q     <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) mem_q[i] <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef AXI4LITE_FLASH_READER_ABORT_ON_ERR_EN
         abort_q   <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         arvalid_q <= arvalid_d;
         count_q   <= count_d;
         issued_q  <= issued_d;
         outst_q   <= outst_d;
         occ_q     <= occ_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         for (int i = 0; i < MAX_OUTSTANDING; i++) mem_q[i] <= mem_d[i];
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef AXI4LITE_FLASH_READER_ABORT_ON_ERR_EN
         abort_q   <= abort_d;
`endif
      end
   end

   // rready follows busy: the credit rule already reserved a FIFO slot for every accepted read.
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign out_valid = (occ_q != '0);
   assign out_data  = mem_q[rd_ptr_q];
   assign araddr    = addr_q;
   assign arprot    = 3'b000;
   assign arvalid   = arvalid_q;
   assign rready    = busy_q;

endmodule

// File: doc/axi4lite_flash_reader.md
Name: axi4lite_flash_reader

Overview:
- AXI4-lite read master that streams a contiguous range of 64-bit words out of the memory-mapped flash slave (axi4lite_flash) into a simple valid/ready sink.
- Used by boot copy and instruction prefetch logic.
- Keeps up to MAX_OUTSTANDING reads in flight, so it exercises the slave's overlapped-read path.
- Data is delivered in request order through a small internal FIFO.

Parameters:
ADDR_WIDTH, 24, AXI byte address width
DATA_WIDTH, 64, AXI data width; address stride = DATA_WIDTH/8
LEN_WIDTH, 16, width of word_count
MAX_OUTSTANDING, 2, max reads in flight plus buffered words; equals FIFO depth, >=1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
start  in  1  begin transfer; sampled only in IDLE
start_addr  in  ADDR_WIDTH  first byte address, DATA_WIDTH/8 aligned
word_count  in  LEN_WIDTH  number of words; 0 = no-op
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of transfer
error  out  1  sticky: any non-OKAY rresp; cleared on accepted start
out_data  out  DATA_WIDTH  streamed word
out_valid  out  1  out_data valid
out_ready  in  1  sink accepts word
araddr  out  ADDR_WIDTH  AXI read address
arprot  out  3  constant 3'b000
arvalid  out  1  AXI read address valid
arready  in  1  AXI read address ready
rdata  in  DATA_WIDTH  AXI read data
rresp  in  2  AXI read response
rvalid  in  1  AXI read data valid
rready  out  1  AXI read data ready

Behaviour:
- Reset (async, rst=0): state IDLE.
  - Outputs: busy=0, done=0, error=0, out_valid=0, arvalid=0, rready=0, araddr=0.
  - FIFO and all counters cleared.
  - Reset mid-transfer drops arvalid immediately; in-flight responses are forgotten.
- States: IDLE -> RUN -> DRAIN -> FIN -> IDLE.
- IDLE:
  - start=1 with word_count!=0 -> RUN: latch address and count, busy=1, error=0.
  - start=1 with word_count=0 -> FIN directly: no AR issued; done pulses the next cycle.
- RUN:
  - arvalid is asserted when issued<word_count and (outstanding + fifo_occupancy) < MAX_OUTSTANDING.
  - Once asserted, araddr and arvalid stay stable until arready.
  - On each AR handshake: address += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH; issued++; outstanding++.
  - New arvalid may be presented in the same cycle as the handshake if the credit rule still allows it (back-to-back issue).
  - Last AR accepted -> DRAIN.
- rready=1 whenever busy. The credit rule guarantees FIFO space, so rready never depends on out_ready.
- R handshake: push rdata into FIFO; outstanding--.
  - rresp != 2'b00 sets error.
  - Word is still pushed unless the optional feature is active.
- Same-cycle AR handshake and R handshake: outstanding is unchanged; the counter must not glitch.
- FIFO output:
  - out_valid = not empty; pop on out_valid & out_ready.
  - out_data holds stable while out_valid=1 and out_ready=0.
  - Push and pop in the same cycle with the FIFO full is legal: occupancy unchanged.
- DRAIN: wait for outstanding=0 and FIFO empty -> FIN.
- FIN: done=1 for exactly one cycle, busy=0 in that cycle -> IDLE.
- start while busy is ignored.
- Latency: first arvalid 1 cycle after the accepted start. First out_valid 1 cycle after the first R handshake.

Optional Feature:
- Macro: AXI4LITE_FLASH_READER_ABORT_ON_ERR_EN.
- Defined:
  - The first non-OKAY rresp stops further AR issue; a pending arvalid still completes its handshake.
  - The erroring word and all later responses are discarded, not pushed.
  - Words already in the FIFO are still delivered.
  - Then DRAIN -> FIN as normal; error=1.
- Undefined:
  - All word_count reads are issued and all words are delivered in order.
  - error only flags the failure.

Test Plan:
- Single read: start_addr=0xAABBCC, count=1, flash pattern mock -> one AR at 0xAABBCC; out_data equals the pattern (byte = a[7:0]^a[15:8]^a[23:16] at each address a .. a+7); done 1 cycle; error=0.
- Streaming: start_addr=0x000010, count=4, out_ready=1 -> ARs at 0x10, 0x18, 0x20, 0x28 in order; never more than 2 outstanding; 4 words in order; one done pulse.
- Backpressure: count=6, out_ready=0 for 30 cycles, then 1 -> no further AR after 2 reads issued; no word lost or duplicated; all 6 delivered; out_data stable while stalled.
- Wrap: start_addr=0xFFFFF8, count=2 -> ARs at 0xFFFFF8 then 0x000000.
- Error: slave returns SLVERR on the 2nd of 3 reads -> error=1.
  - Feature off: 3 words out.
  - Feature on: 1 word out, no AR after the error response, done still pulses.
- Edge cases:
  - count=0 -> done pulse, no arvalid.
  - start asserted during RUN is ignored.
  - rst=0 in RUN -> arvalid=0 and busy=0 asynchronously; a fresh start afterwards works.
